// File: rtl/uart_tx_pkg.sv
// Shared register map, status/control bit positions and sequencer states
// for the UART transmit front-end.
package uart_tx_pkg;

  localparam logic [3:0] REG_TXDATA = 4'd0;
  localparam logic [3:0] REG_BAUD   = 4'd1;
  localparam logic [3:0] REG_STATUS = 4'd2;
  localparam logic [3:0] REG_CTRL   = 4'd3;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 4;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_CLR_OVF_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LAUNCH     = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push is accepted when not full or when a pop
// frees a slot in the same cycle. Flush has priority over push and pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_push_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_count     = r_count;
  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_empty     = (r_count == {(AW+1){1'b0}});
  assign o_rdata     = r_mem[r_rd_ptr];
  assign w_pop_ok    = i_pop && !o_empty;
  assign w_push_ok   = i_push && (!o_full || w_pop_ok);
  assign o_push_drop = i_push && !w_push_ok && !i_flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Bus-mapped UART transmit front-end: byte FIFO, baud register, status, and a
// sequencer that feeds the uart transmit/tx_byte strobe interface.
module uart_tx_buffer
  import uart_tx_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int DEFAULT_BAUD  = 651,
  parameter int START_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_addr_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        transmit_o,
  output logic [7:0]  tx_byte_o,
  input  logic        is_transmitting_i,
  output logic [15:0] baud_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  seq_state_e  r_state;
  seq_state_e  w_state_nxt;
  logic [TW-1:0] r_to_cnt;
  logic        r_transmit;
  logic        w_transmit_nxt;
  logic [7:0]  r_tx_byte;
  logic [7:0]  w_tx_byte_nxt;
  logic [15:0] r_baud;
  logic        r_overflow;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [31:0] w_rmux;
  logic [31:0] w_status;

  logic        w_wr;
  logic        w_push;
  logic        w_ctrl_wr;
  logic        w_flush;
  logic        w_clr_ovf;
  logic        w_pop;
  logic [7:0]  w_head;
  logic [CW-1:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_push_drop;

  assign data_gnt_o    = data_req_i;
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign transmit_o    = r_transmit;
  assign tx_byte_o     = r_tx_byte;
  assign baud_o        = r_baud;

  assign w_wr      = data_req_i && data_we_i;
  assign w_push    = w_wr && (data_addr_i == REG_TXDATA) && data_be_i[0];
  assign w_ctrl_wr = w_wr && (data_addr_i == REG_CTRL) && data_be_i[0];
  assign w_flush   = w_ctrl_wr && data_wdata_i[CTRL_FLUSH_BIT];
  assign w_clr_ovf = w_ctrl_wr && data_wdata_i[CTRL_CLR_OVF_BIT];
  assign w_pop     = (r_state == ST_LAUNCH);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_wdata     (data_wdata_i[7:0]),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_rdata     (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_push_drop (w_push_drop)
  );

  // Status word assembly and read-data mux.
  always_comb begin
    w_status                          = 32'h0;
    w_status[STAT_COUNT_LSB +: CW]    = w_count;
    w_status[STAT_OVF_BIT]            = r_overflow;
    w_status[STAT_BUSY_BIT]           = (r_state != ST_IDLE);
    w_status[STAT_FULL_BIT]           = w_full;
    w_status[STAT_EMPTY_BIT]          = w_empty;
    case (data_addr_i)
      REG_BAUD:   w_rmux = {16'h0, r_baud};
      REG_STATUS: w_rmux = w_status;
      default:    w_rmux = 32'h0;
    endcase
  end

  // Sequencer next state; the strobe is decided one cycle early so it leaves a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_transmit_nxt = 1'b0;
    w_tx_byte_nxt  = r_tx_byte;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt    = ST_LAUNCH;
          w_transmit_nxt = 1'b1;
          w_tx_byte_nxt  = w_head;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LAUNCH: w_state_nxt = ST_WAIT_START;
      ST_WAIT_START: begin
        if (is_transmitting_i) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_to_cnt == TW'(START_TIMEOUT - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        if (!is_transmitting_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state, start timeout and uart strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_to_cnt   <= {TW{1'b0}};
      r_transmit <= 1'b0;
      r_tx_byte  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_to_cnt   <= (r_state == ST_WAIT_START) ? r_to_cnt + {{(TW-1){1'b0}}, 1'b1}
                                               : {TW{1'b0}};
      r_transmit <= w_transmit_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
    end
  end

  // Bus response, baud register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'h0;
      r_baud     <= 16'(DEFAULT_BAUD);
      r_overflow <= 1'b0;
    end else begin
      r_rvalid <= data_req_i;
      r_rdata  <= data_req_i ? w_rmux : 32'h0;
      if (w_wr && (data_addr_i == REG_BAUD)) begin
        if (data_be_i[0]) r_baud[7:0]  <= data_wdata_i[7:0];
        if (data_be_i[1]) r_baud[15:8] <= data_wdata_i[15:8];
      end
      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end else if (w_clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: bus access, FIFO overflow/flush,
// launch latency, start timeout and mid-transmission reset.
module tb_uart_tx_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_addr_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        transmit_o;
  logic [7:0]  tx_byte_o;
  logic        is_transmitting_i;
  logic [15:0] baud_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pulse = 0;
  logic [7:0] pulse_byte [16];
  int pulse_cyc [16];

  uart_tx_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .data_req_i        (data_req_i),
    .data_we_i         (data_we_i),
    .data_addr_i       (data_addr_i),
    .data_be_i         (data_be_i),
    .data_wdata_i      (data_wdata_i),
    .data_gnt_o        (data_gnt_o),
    .data_rvalid_o     (data_rvalid_o),
    .data_rdata_o      (data_rdata_o),
    .transmit_o        (transmit_o),
    .tx_byte_o         (tx_byte_o),
    .is_transmitting_i (is_transmitting_i),
    .baud_o            (baud_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every transmit strobe seen by the uart.
  always @(negedge clk) begin
    if (transmit_o) begin
      if (n_pulse < 16) begin
        pulse_byte[n_pulse] = tx_byte_o;
        pulse_cyc[n_pulse]  = cyc;
      end
      n_pulse = n_pulse + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_addr_i  = a;
    data_be_i    = be;
    data_wdata_i = d;
    @(negedge clk);
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic v;
    logic [31:0] d;
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_addr_i = a;
    data_be_i   = 4'hF;
    @(negedge clk);
    v = data_rvalid_o;
    d = data_rdata_o;
    data_req_i = 1'b0;
    check_val({tag, "_rvalid"}, {31'h0, v}, 32'h1);
    check_val(tag, d, exp);
  endtask

  initial begin
    rst = 1'b1;
    data_req_i = 1'b0;
    data_we_i = 1'b0;
    data_addr_i = 4'h0;
    data_be_i = 4'h0;
    data_wdata_i = 32'h0;
    is_transmitting_i = 1'b0;
    tick(3);
    check_val("rst_transmit", {31'h0, transmit_o}, 32'h0);
    check_val("rst_txbyte", {24'h0, tx_byte_o}, 32'h0);
    check_val("rst_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    check_val("rst_rdata", data_rdata_o, 32'h0);
    check_val("rst_baud", {16'h0, baud_o}, 32'd651);
    rst = 1'b0;
    tick(1);

    // Register map basics
    read_check("baud_after_rst", 4'd1, 32'h0000028B);
    read_check("status_idle", 4'd2, 32'h00000001);
    read_check("txdata_read", 4'd0, 32'h0);
    read_check("unmapped_read", 4'd9, 32'h0);
    data_req_i = 1'b1;
    #1 check_val("gnt_comb", {31'h0, data_gnt_o}, 32'h1);
    data_req_i = 1'b0;
    #1 check_val("gnt_low", {31'h0, data_gnt_o}, 32'h0);
    tick(1);
    bus_write(4'd1, 4'b0001, 32'h00001234);
    check_val("baud_low_byte", {16'h0, baud_o}, 32'h0234);
    read_check("baud_readback", 4'd1, 32'h00000234);

    // Launch latency: write in T, rvalid in T+1, strobe only in T+2
    bus_write(4'd0, 4'b0001, 32'h00000041);
    check_val("lat_rvalid_t1", {31'h0, data_rvalid_o}, 32'h1);
    check_val("lat_tx_t1", {31'h0, transmit_o}, 32'h0);
    tick(1);
    check_val("lat_tx_t2", {31'h0, transmit_o}, 32'h1);
    check_val("lat_byte_t2", {24'h0, tx_byte_o}, 32'h41);
    check_val("lat_rvalid_t2", {31'h0, data_rvalid_o}, 32'h0);
    is_transmitting_i = 1'b1;
    tick(1);
    check_val("lat_tx_t3", {31'h0, transmit_o}, 32'h0);
    tick(2);
    read_check("status_busy", 4'd2, 32'h00000005);
    is_transmitting_i = 1'b0;
    tick(3);
    read_check("status_done", 4'd2, 32'h00000001);

    // Overflow: 18 bytes while the uart stays busy
    is_transmitting_i = 1'b1;
    for (int i = 0; i < 18; i++) bus_write(4'd0, 4'b0001, 32'(i));
    read_check("status_full_ovf", 4'd2, 32'h00001016);
    bus_write(4'd3, 4'b0001, 32'h1);
    read_check("status_ovf_clr", 4'd2, 32'h00001006);
    bus_write(4'd3, 4'b0001, 32'h2);
    read_check("status_flushed", 4'd2, 32'h00000005);
    is_transmitting_i = 1'b0;
    tick(6);
    read_check("status_after_flush", 4'd2, 32'h00000001);
    check_val("pulses_after_flush", 32'(n_pulse), 32'd2);
    check_val("ovf_first_byte", {24'h0, pulse_byte[1]}, 32'h00);

    // Start timeout: uart never acknowledges
    bus_write(4'd0, 4'b0001, 32'h55);
    bus_write(4'd0, 4'b0001, 32'h66);
    tick(15);
    check_val("to_pulses", 32'(n_pulse), 32'd4);
    check_val("to_byte_a", {24'h0, pulse_byte[2]}, 32'h55);
    check_val("to_byte_b", {24'h0, pulse_byte[3]}, 32'h66);
    check_val("to_spacing", 32'(pulse_cyc[3] - pulse_cyc[2]), 32'd6);
    read_check("to_status", 4'd2, 32'h00000001);

    // Reset during WAIT_DONE with 3 queued and a read in flight
    is_transmitting_i = 1'b1;
    for (int i = 0; i < 4; i++) bus_write(4'd0, 4'b0001, 32'h70 + 32'(i));
    tick(3);
    read_check("pre_rst_status", 4'd2, 32'h00000304);
    rst = 1'b1;
    data_req_i = 1'b1;
    data_we_i = 1'b0;
    data_addr_i = 4'd1;
    tick(1);
    rst = 1'b0;
    data_req_i = 1'b0;
    check_val("mid_rst_transmit", {31'h0, transmit_o}, 32'h0);
    check_val("mid_rst_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    check_val("mid_rst_rdata", data_rdata_o, 32'h0);
    check_val("mid_rst_baud", {16'h0, baud_o}, 32'd651);
    read_check("mid_rst_status", 4'd2, 32'h00000001);
    tick(3);
    check_val("mid_rst_pulses", 32'(n_pulse), 32'd5);
    check_val("mid_rst_byte", {24'h0, pulse_byte[4]}, 32'h70);
    is_transmitting_i = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Memory-mapped UART transmit front-end that responds to the core data bus (req/gnt/rvalid protocol) on the UART peripheral slot. CPU byte writes go into a DEPTH-entry FIFO. A sequencer drains the FIFO into the uart transmitter's transmit/tx_byte strobe interface, pacing on is_transmitting. It also owns the baud register and exposes TX status to software.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
DEFAULT_BAUD, 651, reset value of baud_o.
START_TIMEOUT, 4, cycles to wait for is_transmitting_i to rise after a launch.

Ports:
clk  in  1  system clock (msoc_clk).
rst  in  1  synchronous active-high reset.
data_req_i  in  1  bus request.
data_we_i  in  1  1 = write.
data_addr_i  in  4  word offset (bus address bits [5:2]).
data_be_i  in  4  byte enables.
data_wdata_i  in  32  write data.
data_gnt_o  out  1  grant.
data_rvalid_o  out  1  response valid.
data_rdata_o  out  32  read data.
transmit_o  out  1  one-cycle strobe to the uart.
tx_byte_o  out  8  byte to transmit; valid while transmit_o is high.
is_transmitting_i  in  1  uart busy flag.
baud_o  out  16  uart baud divisor.

Behaviour:
- Register map (word offsets):
  - 0 TXDATA: write-only. Write pushes wdata[7:0] when be[0]=1. Reads return 0.
  - 1 BAUD: read/write. Bits [15:0]. be[0] updates the low byte, be[1] the high byte.
  - 2 STATUS: read-only. {count[log2(DEPTH):0] at bit 8 and up, overflow bit 4, busy bit 2, full bit 1, empty bit 0}. busy = state != IDLE.
  - 3 CTRL: write-only. bit0 = 1 clears overflow; bit1 = 1 flushes the FIFO.
  - Offsets 4-15: writes ignored, reads return 0.
- Bus handshake:
  - data_gnt_o = data_req_i, combinational, zero wait states.
  - data_rvalid_o is registered high exactly one cycle after each granted request, for reads and writes alike.
  - data_rdata_o is registered; it carries the value sampled in the grant cycle while rvalid=1 and is 0 otherwise.
  - Back-to-back requests every cycle are supported.
- FIFO:
  - Push is accepted if not full, or if a pop happens in the same cycle.
  - A rejected push sets the sticky overflow flag; the byte is dropped.
  - Flush empties the FIFO next cycle. It does not abort a byte already launched.
  - If a CTRL flush and a TXDATA push land in the same cycle, flush wins. This cannot occur on a single bus, but the priority is defined anyway.
- Sequencer FSM (state register resets to IDLE):
  - IDLE: FIFO not empty -> LAUNCH.
  - LAUNCH: transmit_o=1 and tx_byte_o=FIFO head, registered. Pop the head. Go to WAIT_START.
  - WAIT_START: is_transmitting_i=1 -> WAIT_DONE. After START_TIMEOUT cycles without it -> IDLE; the byte counts as sent.
  - WAIT_DONE: is_transmitting_i=0 -> IDLE.
- Latency:
  - Write to TXDATA in cycle T on an idle, empty block gives transmit_o=1 in cycle T+2.
  - Consecutive bytes are separated by at least 2 cycles after is_transmitting_i falls.
- Baud: baud_o updates the cycle after the write, including mid-transmission. No interlock.
- Reset, any time including mid-transmission, sets:
  - FIFO empty, overflow=0, state IDLE.
  - transmit_o=0, tx_byte_o=0.
  - data_rvalid_o=0, data_rdata_o=0.
  - baud_o=DEFAULT_BAUD.
  - Any in-flight bus response is dropped.
- Count arithmetic: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, so full reads as count=DEPTH.

Decomposition:
- Package uart_tx_pkg holds:
  - register offset constants (TXDATA=0, BAUD=1, STATUS=2, CTRL=3);
  - STATUS and CTRL bit positions;
  - the sequencer state enum (IDLE, LAUNCH, WAIT_START, WAIT_DONE).
- Sub-module sync_fifo (parameters WIDTH, DEPTH; outputs count, full, empty; flush input). It is reusable for the RX path.

Test Plan:
- Idle, write 0x41 to offset 0 at cycle T -> transmit_o high only in T+2 with tx_byte_o=0x41. rvalid high at T+1.
- Model holds is_transmitting_i=1. Write 18 bytes 0x00..0x11 -> 0x00 launched, 16 buffered, 0x11 dropped. STATUS reads full=1, overflow=1, count=16. CTRL write 0x1 -> overflow=0.
- Read BAUD after reset -> 0x0000028B. Write 0x1234 with be=4'b0001 -> baud_o=0x0234 the next cycle.
- Byte in WAIT_DONE with 5 queued; CTRL write 0x2 -> count=0 next cycle. Current byte completes and no further transmit_o pulses occur.
- is_transmitting_i stuck at 0 after a launch -> FSM returns to IDLE after 4 cycles and the next queued byte launches.
- Assert rst during WAIT_DONE with 3 queued -> the next cycle shows empty=1, busy=0, transmit_o=0, baud_o=651.
